// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   fetch_state_t  : fetch FSM states (run, flush of stale responses, halt on bad target)
//   DefaultResetPc : default first fetch address after reset
//   fetch_entry_t  : prefetch buffer entry {instruction word, its address}
package rv_fetch_pkg;

    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StHalt
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch buffer: synchronous DEPTH-entry FIFO of {data, pc} entries.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : empty the buffer (takes priority over push/pop)
//   push, push_data/pc   : write an entry at the tail
//   pop                  : drop the head entry (ignored when empty)
//   head_data, head_pc   : head entry, combinational
//   full, empty, count   : occupancy status
// A push on a full buffer is accepted when a pop happens in the same cycle.
module fetch_buffer
    import rv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [31:0]            push_data,
    input  logic [31:0]            push_pc,
    input  logic                   pop,
    output logic [31:0]            head_data,
    output logic [31:0]            head_pc,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem_q[rd_ptr_q].data;
    assign head_pc   = mem_q[rd_ptr_q].pc;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible when count is nonzero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= '{data: push_data, pc: push_pc};
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches to instruction memory,
// queues returned words in a prefetch buffer and presents them to control_unit.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   imem_req/addr, imem_gnt         : fetch request channel
//   imem_rvalid, imem_rdata         : in-order response channel
//   ins, ins_pc, iready, ins_take   : head instruction to the consumer
//   pcsel, redirect_pc              : redirect from control_unit
//   fetch_misalign                  : sticky misaligned-redirect flag
// Build option: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets
// (set fetch_misalign and halt until an aligned redirect). Without it, the low two
// target bits are ignored and fetch_misalign is tied low.
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        iready,
    input  logic        ins_take,
    input  logic        pcsel,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outs_q, outs_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] buf_count;
    logic [CW:0]   occ_sum;
    logic          buf_full, buf_empty;
    logic [31:0]   head_data, head_pc;
    logic [31:0]   target;
    logic          target_bad;
    logic          pop, gnt_fire, rsp_fire, rsp_drop, push;

    assign target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_bad = |redirect_pc[1:0];
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign target_bad          = 1'b0;
`endif

    assign iready = !buf_empty;
    assign ins    = iready ? head_data : '0;
    assign ins_pc = iready ? head_pc : '0;
    assign pop    = ins_take && iready && !pcsel;

    // Credit counts the slot freed by a same-cycle pop so a consuming pipeline
    // streams back to back. Once raised, the credit can only grow until granted,
    // so the request stays up with a stable address.
    assign occ_sum   = {1'b0, buf_count} + {1'b0, outs_q} - {{CW{1'b0}}, pop};
    assign imem_req  = rst_n && (state_q != StHalt) && (occ_sum < (CW + 1)'(DEPTH));
    assign imem_addr = addr_q;

    assign gnt_fire = imem_req && imem_gnt;
    // A response with nothing outstanding is a stray (e.g. from before reset).
    assign rsp_fire = imem_rvalid && (outs_q != '0);
    assign rsp_drop = rsp_fire && ((disc_q != '0) || pcsel || (state_q == StHalt));
    assign push     = rsp_fire && !rsp_drop && (!buf_full || pop);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rsp_pc_d = rsp_pc_q;
        disc_d   = disc_q;
        outs_d   = outs_q + {{(CW - 1){1'b0}}, gnt_fire} - {{(CW - 1){1'b0}}, rsp_fire};

        if (gnt_fire) addr_d = addr_q + 32'd4;
        // Kept responses are contiguous from the last redirect target.
        if (push) rsp_pc_d = rsp_pc_q + 32'd4;
        if (rsp_fire && (disc_q != '0)) disc_d = disc_q - CW'(1);

        case (state_q)
            StFlush: if (disc_d == '0) state_d = StRun;
            default: begin
            end
        endcase

        if (pcsel) begin
            addr_d   = target;
            rsp_pc_d = target;
            // Everything still in flight, including this cycle's grant, is stale.
            disc_d   = outs_d;
            if (target_bad) begin
                state_d = StHalt;
            end else if (outs_d != '0) begin
                state_d = StFlush;
            end else begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            addr_q   <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outs_q   <= '0;
            disc_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rsp_pc_q <= rsp_pc_d;
            outs_q   <= outs_d;
            disc_q   <= disc_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (pcsel && target_bad) begin
            misalign_q <= 1'b1;
        end
    end

    assign fetch_misalign = misalign_q;
`else
    assign fetch_misalign = 1'b0;
`endif

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (pcsel),
        .push      (push),
        .push_data (imem_rdata),
        .push_pc   (rsp_pc_q),
        .pop       (pop),
        .head_data (head_data),
        .head_pc   (head_pc),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a directed vector table, hand sequences for
// stall, reset-with-outstanding and redirect-target handling, then a random
// run against a stream-level model (memory queue + expected buffer contents).
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        iready;
    logic        ins_take = 1'b0;
    logic        pcsel = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_misalign;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (RPC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .iready         (iready),
        .ins_take       (ins_take),
        .pcsel          (pcsel),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rv_pc;
        logic        take;
        logic        psel;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_rdy;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        bit          keep;
    } pend_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    vec_t        tbl [14];
    pend_t       memq[$];
    ent_t        mbuf[$];
    logic [31:0] next_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic tk, input logic ps, input logic [31:0] rp);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        ins_take    = tk;
        pcsel       = ps;
        redirect_pc = rp;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("reset imem_req", 32'(imem_req), 32'h0);
        check("reset imem_addr", imem_addr, RPC);
        check("reset iready", 32'(iready), 32'h0);
        check("reset ins", ins, 32'h0);
        check("reset ins_pc", ins_pc, 32'h0);
        check("reset fetch_misalign", 32'(fetch_misalign), 32'h0);
        repeat (2) @(posedge clk);
        memq.delete();
        mbuf.delete();
        next_addr = RPC;
    endtask

    initial begin
        //            gnt   rv    rv_pc    take  psel  rpc        req   addr       rdy   pc
        tbl[0]  = '{1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 1'b1, 32'h000, 1'b0, 32'h000};
        tbl[1]  = '{1'b1, 1'b1, 32'h000, 1'b1, 1'b0, 32'h000, 1'b1, 32'h004, 1'b0, 32'h000};
        tbl[2]  = '{1'b1, 1'b1, 32'h004, 1'b1, 1'b0, 32'h000, 1'b1, 32'h008, 1'b1, 32'h000};
        tbl[3]  = '{1'b1, 1'b1, 32'h008, 1'b1, 1'b0, 32'h000, 1'b1, 32'h00C, 1'b1, 32'h004};
        tbl[4]  = '{1'b1, 1'b1, 32'h00C, 1'b0, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h008};
        tbl[5]  = '{1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h008};
        tbl[6]  = '{1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h010, 1'b1, 32'h008};
        tbl[7]  = '{1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 1'b1, 32'h010, 1'b1, 32'h008};
        tbl[8]  = '{1'b1, 1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 1'b1, 32'h014, 1'b1, 32'h00C};
        tbl[9]  = '{1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 32'h100, 1'b0, 32'h018, 1'b0, 32'h000};
        tbl[10] = '{1'b1, 1'b1, 32'h010, 1'b0, 1'b0, 32'h000, 1'b0, 32'h100, 1'b0, 32'h000};
        tbl[11] = '{1'b1, 1'b1, 32'h014, 1'b0, 1'b0, 32'h000, 1'b1, 32'h100, 1'b0, 32'h000};
        tbl[12] = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h000, 1'b1, 32'h104, 1'b0, 32'h000};
        tbl[13] = '{1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h108, 1'b1, 32'h100};

        // Streaming, back-pressure and redirect with two requests in flight.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step();
            drive(tbl[i].gnt, tbl[i].rv, word_at(tbl[i].rv_pc), tbl[i].take, tbl[i].psel,
                  tbl[i].rpc);
            @(negedge clk);
            check($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            check($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("vec%0d iready", i), 32'(iready), 32'(tbl[i].e_rdy));
            check($sformatf("vec%0d ins_pc", i), ins_pc, tbl[i].e_pc);
            check($sformatf("vec%0d ins", i), ins, tbl[i].e_rdy ? word_at(tbl[i].e_pc) : 32'h0);
        end

        // Grant withheld for 5 cycles: request and address held, buffer drains.
        for (int k = 0; k < 5; k++) begin
            step();
            drive(1'b0, k == 0, word_at(32'h104), 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            check("stall imem_req", 32'(imem_req), 32'h1);
            check("stall imem_addr", imem_addr, 32'h108);
        end
        check("stall drained iready", 32'(iready), 32'h0);

        // Reset with two requests outstanding; a late response must be ignored.
        for (int k = 0; k < 2; k++) begin
            step();
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            check("pre-reset grant", 32'(imem_req), 32'h1);
        end
        do_reset();
        step();
        drive(1'b0, 1'b1, 32'h0BAD_C0DE, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("post-reset imem_req", 32'(imem_req), 32'h1);
        check("post-reset imem_addr", imem_addr, RPC);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("stray rvalid ignored", 32'(iready), 32'h0);
        check("post-reset re-request", imem_addr, RPC);
        step();
        drive(1'b0, 1'b1, word_at(RPC), 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("post-reset wait iready", 32'(iready), 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("post-reset iready", 32'(iready), 32'h1);
        check("post-reset ins_pc", ins_pc, RPC);
        check("post-reset ins", ins, word_at(RPC));

        // Misaligned redirect target, then an aligned one.
        do_reset();
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h102);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            step();
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
            check("misalign flag", 32'(fetch_misalign), 32'h1);
            check("misalign halt imem_req", 32'(imem_req), 32'h0);
`else
            check("misalign flag tied", 32'(fetch_misalign), 32'h0);
            check("misalign masked imem_req", 32'(imem_req), 32'h1);
            check("misalign masked imem_addr", imem_addr, 32'h100);
`endif
            check("misalign iready", 32'(iready), 32'h0);
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
        @(negedge clk);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("resume imem_req", 32'(imem_req), 32'h1);
        check("resume imem_addr", imem_addr, 32'h200);
`ifdef FETCH_ALIGN_CHECK_EN
        check("misalign sticky", 32'(fetch_misalign), 32'h1);
`else
        check("misalign still low", 32'(fetch_misalign), 32'h0);
`endif

        // Random traffic against the stream model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        g, rv, tk, ps;
            logic [31:0] rp, rd;
            bit          pop_now, exp_req;
            pend_t       h;
            step();
            g  = ($urandom_range(0, 3) != 0);
            rv = (memq.size() > 0) && ($urandom_range(0, 2) != 0);
            rd = rv ? word_at(memq[0].addr) : $urandom;
            tk = ($urandom_range(0, 2) != 0);
            ps = ($urandom_range(0, 24) == 0);
            rp = $urandom & 32'h0000_FFFC;
            drive(g, rv, rd, tk, ps, rp);
            @(negedge clk);
            pop_now = tk && (mbuf.size() > 0) && !ps;
            exp_req = (mbuf.size() + memq.size() - (pop_now ? 1 : 0)) < int'(DEPTH);
            check("rnd imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) check("rnd imem_addr", imem_addr, next_addr);
            check("rnd iready", 32'(iready), 32'(mbuf.size() > 0));
            if (mbuf.size() > 0) begin
                check("rnd ins_pc", ins_pc, mbuf[0].pc);
                check("rnd ins", ins, mbuf[0].data);
            end
            if (ps) begin
                mbuf.delete();
                foreach (memq[k]) memq[k].keep = 1'b0;
                if (rv) void'(memq.pop_front());
                if (exp_req && g) memq.push_back('{next_addr, 1'b0});
                next_addr = rp;
            end else begin
                if (pop_now) void'(mbuf.pop_front());
                if (rv) begin
                    h = memq.pop_front();
                    if (h.keep) mbuf.push_back('{word_at(h.addr), h.addr});
                end
                if (exp_req && g) begin
                    memq.push_back('{next_addr, 1'b1});
                    next_addr = next_addr + 32'd4;
                end
            end
        end
        check("rnd fetch_misalign", 32'(fetch_misalign), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, prefetch buffer entries and maximum outstanding requests (power of two, 2..8).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch word address, bits [1:0] always 2'b00.
REQ-007 imem_gnt  input  1  request accepted this cycle when high with imem_req.
REQ-008 imem_rvalid  input  1  response valid, responses in request order, earliest one cycle after grant.
REQ-009 imem_rdata  input  32  response instruction word.
REQ-010 ins  output  32  instruction word at buffer head, to control_unit.
REQ-011 ins_pc  output  32  address of ins.
REQ-012 iready  output  1  ins/ins_pc valid.
REQ-013 ins_take  input  1  consumer pops head this cycle; ignored when iready=0.
REQ-014 pcsel  input  1  redirect request from control_unit.
REQ-015 redirect_pc  input  32  redirect target, sampled when pcsel=1.
REQ-016 fetch_misalign  output  1  sticky misaligned-target flag (only with FETCH_ALIGN_CHECK_EN).

Function
REQ-017 Request issued only when buffer occupancy + outstanding < DEPTH; fetch address increments by 4 per grant.
REQ-018 Each non-discarded response writes {imem_rdata, its address} into buffer tail in order.
REQ-019 iready = buffer not empty; ins/ins_pc driven from head combinationally; zero-latency pop on ins_take.
REQ-020 Response arriving to empty buffer becomes visible on iready the following cycle (registered write).
REQ-021 Simultaneous pop and push on a full buffer accepted in the same cycle without loss.
REQ-022 FSM states RUN, FLUSH, HALT; reset to RUN.
REQ-023 pcsel=1 in any state: buffer emptied, iready=0 next cycle, fetch address := redirect_pc, discard counter := outstanding count (including a request granted that cycle); pcsel overrides ins_take.
REQ-024 FLUSH entered when discard counter nonzero; each imem_rvalid decrements it without buffer write; return to RUN at zero; new requests allowed during FLUSH within the credit limit and tagged keep.
REQ-025 Outstanding and discard counters width clog2(DEPTH)+1; never wrap; response with zero outstanding is a protocol error, ignored.
REQ-026 imem_req held with stable imem_addr until granted unless pcsel redirects.

Reset
REQ-027 On rst_n low: imem_req=0, imem_addr=RESET_PC, iready=0, ins=0, ins_pc=0, fetch_misalign=0, counters 0, state RUN; first request in first cycle after release.
REQ-028 Reset mid-transaction abandons outstanding requests; stray responses after release are ignored via zero outstanding count.

Configuration
REQ-029 Macro FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 sets fetch_misalign, enters HALT (imem_req=0, iready=0) until a later aligned pcsel.
REQ-030 Macro undefined: redirect_pc[1:0] forced to 2'b00, fetch_misalign tied 0, HALT unreachable.

Structure
REQ-031 Shared package rv_fetch_pkg: fetch state enum, RESET_PC default, buffer entry struct {data, pc}.
REQ-032 One sub-module fetch_buffer: synchronous DEPTH-entry FIFO with flush, push, pop, full, empty.

Verification
REQ-033 Reset release, imem_gnt=1, rvalid 1-cycle latency, ins_take=1 -> addresses 0,4,8 issued back to back, iready high from cycle 3, ins_pc 0,4,8.
REQ-034 ins_take=0, gnt always 1 -> exactly DEPTH=2 requests granted, imem_req low, iready high, ins stable.
REQ-035 pcsel=1, redirect_pc=32'h100 with 2 outstanding -> both returning words dropped, next ins_pc=32'h100.
REQ-036 imem_gnt low 5 cycles -> imem_req and imem_addr held stable, iready=0 after buffer drains.
REQ-037 FETCH_ALIGN_CHECK_EN, redirect_pc=32'h102 -> fetch_misalign=1, no requests; then pcsel with 32'h200 -> fetch resumes at 32'h200.
REQ-038 rst_n asserted with 2 outstanding -> outputs at reset values immediately; late rvalid ignored, first ins_pc=RESET_PC.
